// File: rtl/deserializador_if.sv
// Receiver-side bundle: serial line and sample controls in, word plus status pulses out.
interface deserializador_if #(parameter int N = 4);
    logic         enb;
    logic         dir;
    logic         s_in;
    logic         ready;
    logic [N-1:0] q;
    logic         valid;
    logic         err_paridad;
    logic         err_trama;
    logic         desborde;

    modport master (output enb, dir, s_in, ready,
                    input  q, valid, err_paridad, err_trama, desborde);
    modport slave  (input  enb, dir, s_in, ready,
                    output q, valid, err_paridad, err_trama, desborde);
endinterface

// File: rtl/deserializador.sv
// Framed serial receiver: start 1, N data bits, optional even parity, stop 0.
// Good words land in a one-entry buffer drained by a valid/ready handshake.
module deserializador #(
    parameter int N          = 4,
    parameter bit PARIDAD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    deserializador_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [N-1:0]   word_q, word_d;
    logic           dir_q, dir_d;
    logic           par_q, par_d;
    logic           valid_q, valid_d;
    logic           err_par_q, err_par_d;
    logic           err_tra_q, err_tra_d;
    logic           desb_q, desb_d;
    logic           par_bad;

    assign par_bad = PARIDAD_EN && ((^sh_q) ^ par_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            word_q    <= '0;
            dir_q     <= 1'b0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_tra_q <= 1'b0;
            desb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            word_q    <= word_d;
            dir_q     <= dir_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            err_par_q <= err_par_d;
            err_tra_q <= err_tra_d;
            desb_q    <= desb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        word_d    = word_q;
        dir_d     = dir_q;
        par_d     = par_q;
        valid_d   = valid_q;
        err_par_d = 1'b0;
        err_tra_d = 1'b0;
        desb_d    = 1'b0;

        // Consumption is evaluated every cycle; a good word below may re-set valid.
        if (valid_q && bus.ready)
            valid_d = 1'b0;

        if (bus.enb) begin
            unique case (state_q)
                IDLE: if (bus.s_in) begin
                    dir_d   = bus.dir;
                    cnt_d   = '0;
                    state_d = DATA;
                end
                DATA: begin
                    sh_d  = dir_q ? {sh_q[N-2:0], bus.s_in} : {bus.s_in, sh_q[N-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1))
                        state_d = PARIDAD_EN ? PARITY : STOP;
                end
                PARITY: begin
                    par_d   = bus.s_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bus.s_in)
                        err_tra_d = 1'b1;
                    else if (par_bad)
                        err_par_d = 1'b1;
                    else if (valid_q && !bus.ready)
                        desb_d = 1'b1;
                    else begin
                        word_d  = sh_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.q           = word_q;
    assign bus.valid       = valid_q;
    assign bus.err_paridad = err_par_q;
    assign bus.err_trama   = err_tra_q;
    assign bus.desborde    = desb_q;
endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador (N=4, even parity enabled).
module tb_deserializador;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    deserializador_if #(.N(4)) bus();

    deserializador #(.N(4), .PARIDAD_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        bus.enb  = 1'b1;
        bus.s_in = b;
        step();
    endtask

    task automatic stall(input logic b);
        bus.enb  = 1'b0;
        bus.s_in = b;
        step();
    endtask

    // Sends start, 4 data bits in the order chosen by d, parity p, stop s.
    // ready_stop is the ready level presented on the stop-bit edge.
    task automatic send_frame(input logic d, input logic [3:0] w, input logic p,
                              input logic s, input logic ready_stop);
        logic keep_ready;
        keep_ready = bus.ready;
        bus.dir = d;
        bit_in(1'b1);
        for (int i = 0; i < 4; i++) bit_in(d ? w[3-i] : w[i]);
        bit_in(p);
        bus.ready = ready_stop;
        bit_in(s);
        bus.ready = keep_ready;
        bus.enb   = 1'b0;
        bus.s_in  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enb = 1'b1; bus.dir = 1'b1; bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s_in = i[0];
            step();
        end
        bus.s_in = 1'b0;
        rst_n = 1'b1;
        step();
        chk("reset_q", bus.q, 4'b0000);
        chk("reset_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0000);
        for (int i = 0; i < 3; i++) step();
        chk("reset_idle_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0000);
    endtask

    task automatic test_msb_first();
        bus.ready = 1'b1;
        send_frame(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
        chk("msb_q", bus.q, 4'b0110);
        chk("msb_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
        step();
        chk("msb_valid_one_cycle", {3'b000, bus.valid}, 4'b0000);
    endtask

    task automatic test_lsb_stall();
        bus.ready = 1'b1;
        bus.dir = 1'b0;
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        bus.dir = 1'b1;  // ignored: direction latched at start
        stall(1'b1); stall(1'b0); stall(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);    // parity
        bit_in(1'b0);    // stop
        bus.enb = 1'b0; bus.s_in = 1'b0;
        chk("lsb_q", bus.q, 4'b1101);
        chk("lsb_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
        step();
        chk("lsb_valid_one_cycle", {3'b000, bus.valid}, 4'b0000);
    endtask

    task automatic test_frame_errors();
        bus.ready = 1'b1;
        send_frame(1'b1, 4'b0110, 1'b1, 1'b0, 1'b1);
        chk("par_err_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0100);
        step();
        chk("par_err_pulse_end", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0000);
        send_frame(1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
        chk("trama_err_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0010);
        step();
        chk("trama_err_pulse_end", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0000);
    endtask

    task automatic test_overflow();
        bus.ready = 1'b0;
        send_frame(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("ovf_first_q", bus.q, 4'b0110);
        chk("ovf_first_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
        send_frame(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("ovf_second_q", bus.q, 4'b0110);
        chk("ovf_second_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1001);
        step();
        chk("ovf_pulse_end", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
        bus.ready = 1'b1;
        step();
        chk("ovf_drain", {3'b000, bus.valid}, 4'b0000);
        chk("ovf_q_held", bus.q, 4'b0110);
    endtask

    // Frame B starts on the edge after A's stop and completes while A is consumed.
    task automatic test_back_to_back();
        bus.ready = 1'b0;
        send_frame(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        chk("b2b_first_q", bus.q, 4'b0011);
        send_frame(1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
        chk("b2b_second_q", bus.q, 4'b1000);
        chk("b2b_second_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
        bus.ready = 1'b1;
        step();
        chk("b2b_drain", {3'b000, bus.valid}, 4'b0000);
    endtask

    task automatic test_reset_midframe();
        bus.ready = 1'b1;
        bus.dir = 1'b1;
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_q", bus.q, 4'b0000);
        chk("midrst_async_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b0000);
        bus.s_in = 1'b0;
        step();
        rst_n = 1'b1;
        bit_in(1'b0);
        send_frame(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1);
        chk("midrst_q", bus.q, 4'b1001);
        chk("midrst_flags", {bus.valid, bus.err_paridad, bus.err_trama, bus.desborde}, 4'b1000);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.enb = 1'b0; bus.dir = 1'b0; bus.s_in = 1'b0; bus.ready = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_stall();
        test_frame_errors();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/deserializador.md
Name: deserializador

Overview:
- Serial receiver for the framed bit stream produced by the shift register's serial output.
- Samples one bit per enabled clock and checks framing and even parity.
- Reassembles N-bit words and presents them on a one-entry output buffer with a valid/ready handshake.
- Sits downstream of the shift register (transmit side) and feeds a parallel consumer.

Parameters:
- N, 4, data bits per frame (N ≥ 2).
- PARIDAD_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit, parity state skipped.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enb  input  1  bit-sample enable; s_in and dir are ignored when 0.
- dir  input  1  bit order, sampled with the start bit: 1 = MSB first, 0 = LSB first.
- s_in  input  1  serial line; idle level 0.
- ready  input  1  consumer accepts q this cycle when valid=1.
- q  output  N  received word.
- valid  output  1  q holds an unconsumed word.
- err_paridad  output  1  one-cycle pulse: parity mismatch, word dropped.
- err_trama  output  1  one-cycle pulse: stop bit not 0, word dropped.
- desborde  output  1  one-cycle pulse: good word arrived while the buffer was full, new word dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; q=0, valid=0, all error pulses 0; bit counter, shift buffer and latched dir cleared. Any partial frame is discarded.
- Frame on the line: start bit 1, then N data bits, then the parity bit (PARIDAD_EN=1 only), then stop bit 0.
- Parity is even: data bits plus parity bit contain an even number of 1s.
- Bit consumption: exactly one bit per rising edge with enb=1. Cycles with enb=0 freeze the FSM, counter and shift buffer.
- Handshake logic runs every cycle regardless of enb.
- FSM states and transitions:
  - IDLE: on enb=1 and s_in=1, latch dir, clear counter, go to DATA. On s_in=0, stay.
  - DATA: shift s_in into the buffer and increment the counter.
    - dir=1: new bit enters the LSB and existing bits move toward the MSB; first bit ends at q[N-1].
    - dir=0: new bit enters the MSB and existing bits move toward the LSB; first bit ends at q[0].
    - After the N-th bit, go to PARITY if PARIDAD_EN=1, else to STOP.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: evaluate the stop bit, go to IDLE.
- Stop-bit evaluation, on the enabled edge sampling the stop bit, in priority order:
  - s_in=1: err_trama=1 for one cycle; word dropped.
  - Else, parity bad: err_paridad=1 for one cycle; word dropped.
  - Else, valid=1 and ready=0: desborde=1 for one cycle; q unchanged; new word dropped.
  - Else: q ← word, valid=1 on that same edge.
- Latency: q/valid are updated on the edge that samples the stop bit. Minimum frame length is N+3 enabled cycles (N+2 with PARIDAD_EN=0).
- Handshake:
  - valid and ready high at an edge: word consumed, valid cleared.
  - If a good word completes on the same edge as consumption, the new word loads and valid stays 1. This is not an overflow.
- q holds its last value after consumption; it is don't-care while valid=0.
- Back-to-back frames: a start bit may be sampled on the enabled edge right after the stop bit.
- Reset release mid-line: the FSM is in IDLE, so a 1 on s_in is treated as a start bit. The transmitter must hold the line at 0 for at least one enabled cycle after reset.
- dir changes mid-frame are ignored; the latched value applies until the next start bit.
- Error pulses are single-cycle, mutually exclusive, and asserted only on the stop-sample edge.

Test Plan:
- Reset: hold rst_n=0 across several edges while s_in toggles, then release → q=0000, valid=0, no error pulses; the line stays idle.
- MSB first, ready=1 (N=4, PARIDAD_EN=1, enb=1, dir=1): s_in = 1, 0,1,1,0, parity 0, stop 0 → q=0110, valid=1 for exactly one cycle, no errors.
- LSB first with stalls (dir=0): s_in = 1, 1,0,1,1, parity 1, stop 0. Insert 3 enb=0 cycles after the second data bit, with s_in toggling during them → q=1101, valid high for one cycle.
- Frame errors: data 0110 with parity 1 → err_paridad pulse, valid stays 0. Then a correct frame with stop 1 → err_trama pulse, valid stays 0.
- Overflow (ready=0): send 0110, then 1111 (parity 0) → first frame valid=1 with q=0110. Second frame gives a desborde pulse, q=0110 unchanged. Then raise ready=1 → valid clears next edge.
- Reset mid-frame: assert rst_n=0 after 2 data bits, release with s_in=0, then send full frame 1001 (MSB first, parity 0) → q=1001, valid=1, no stale bits from the aborted frame.
